// File: rtl/pe_enable_seq_if.sv
// Configuration, chunk handshake and enable-mask bundle for pe_enable_seq.
// The master side drives config/chunks; the slave side (sequencer) returns the masks.
interface pe_enable_seq_if #(
  parameter int NUM_PE = 8,
  parameter int SZW    = 4,
  parameter int DIMW   = 10
);
  logic              cfg_start;
  logic [SZW-1:0]    patch_size;
  logic [SZW-1:0]    stride;
  logic [DIMW-1:0]   img_w;
  logic [DIMW-1:0]   img_h;
  logic              chunk_valid;
  logic              rmu_stop;
  logic              busy;
  logic              cfg_err;
  logic [NUM_PE-1:0] p_en;
  logic              p_en_valid;
  logic [NUM_PE-1:0] p_en_rmu;
  logic              row_end;
  logic              frame_done;

  modport master (
    output cfg_start, patch_size, stride, img_w, img_h, chunk_valid, rmu_stop,
    input  busy, cfg_err, p_en, p_en_valid, p_en_rmu, row_end, frame_done
  );

  modport slave (
    input  cfg_start, patch_size, stride, img_w, img_h, chunk_valid, rmu_stop,
    output busy, cfg_err, p_en, p_en_valid, p_en_rmu, row_end, frame_done
  );
endinterface

// File: rtl/pe_enable_seq.sv
// Per-lane processor enable generator: walks NUM_PE-column chunks of a frame and
// flags lanes whose column completes a PxP patch window at stride S.
//
//   state | meaning
//   IDLE  | waiting for a legal cfg_start; chunk_valid ignored
//   RUN   | consuming chunks of the current frame; cfg_start ignored
module pe_enable_seq #(
  parameter int NUM_PE = 8,
  parameter int SZW    = 4,
  parameter int DIMW   = 10
) (
  input logic            clk,
  input logic            rst,
  pe_enable_seq_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [SZW-1:0]    p_q, s_q;
  logic [DIMW-1:0]   w_q, h_q;
  logic [DIMW-1:0]   col_base, row, col_ph, row_ph;
  logic [DIMW-1:0]   col_ph_nxt, s_m1, p_m1_in, p_m1;
  logic [DIMW:0]     col_end;
  logic [NUM_PE-1:0] mask;
  logic              stop_q, stop_nxt;
  logic              cfg_ok, cfg_load, cfg_bad, fire;
  logic              row_en, last_col, last_row;

  assign cfg_ok = (bus.patch_size != '0) && (bus.stride != '0) &&
                  (bus.stride <= bus.patch_size) &&
                  (DIMW'(bus.patch_size) <= bus.img_w) &&
                  (DIMW'(bus.patch_size) <= bus.img_h);

  assign p_m1_in  = DIMW'(bus.patch_size) - DIMW'(1);
  assign p_m1     = DIMW'(p_q) - DIMW'(1);
  assign s_m1     = DIMW'(s_q) - DIMW'(1);
  assign row_en   = (row_ph == '0);
  assign col_end  = {1'b0, col_base} + (DIMW+1)'(NUM_PE);
  assign last_col = (col_end >= {1'b0, w_q});
  assign last_row = (row == h_q - DIMW'(1));
  assign stop_nxt = cfg_load ? bus.rmu_stop : (stop_q | bus.rmu_stop);
  assign bus.busy = (state == RUN);

  // Phase counter walks lanes in order; a lane fires when the phase hits zero.
  always_comb begin : mask_walk
    logic [DIMW-1:0] ph;
    logic [DIMW:0]   x;
    ph   = col_ph;
    x    = '0;
    mask = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      x       = {1'b0, col_base} + (DIMW+1)'(i);
      mask[i] = row_en && (ph == '0) && (x < {1'b0, w_q});
      ph      = (ph == '0) ? s_m1 : ph - DIMW'(1);
    end
    col_ph_nxt = ph;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_load  = 1'b0;
    cfg_bad   = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cfg_start) begin
          if (cfg_ok) begin
            cfg_load  = 1'b1;
            state_nxt = RUN;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.chunk_valid) begin
          fire = 1'b1;
          if (last_col && last_row) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q      <= '0;
      s_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_base <= '0;
      row      <= '0;
      col_ph   <= '0;
      row_ph   <= '0;
    end else if (cfg_load) begin
      p_q      <= bus.patch_size;
      s_q      <= bus.stride;
      w_q      <= bus.img_w;
      h_q      <= bus.img_h;
      col_base <= '0;
      row      <= '0;
      col_ph   <= p_m1_in;
      row_ph   <= p_m1_in;
    end else if (fire) begin
      if (last_col) begin
        col_base <= '0;
        col_ph   <= p_m1;
        row      <= row + DIMW'(1);
        row_ph   <= row_en ? s_m1 : row_ph - DIMW'(1);
      end else begin
        col_base <= col_base + DIMW'(NUM_PE);
        col_ph   <= col_ph_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.p_en       <= '0;
      bus.p_en_rmu   <= '0;
      bus.p_en_valid <= 1'b0;
      bus.row_end    <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.cfg_err    <= 1'b0;
      stop_q         <= 1'b0;
    end else begin
      bus.p_en_valid <= fire;
      bus.row_end    <= fire && last_col;
      bus.frame_done <= fire && last_col && last_row;
      bus.cfg_err    <= cfg_bad;
      stop_q         <= stop_nxt;
      if (fire) bus.p_en <= mask;
      // The stop request masks the RMU copy on the very edge it is seen.
      if (stop_nxt)  bus.p_en_rmu <= '0;
      else if (fire) bus.p_en_rmu <= mask;
    end
  end

endmodule

// File: tb/tb_pe_enable_seq.sv
// Scoreboard bench for pe_enable_seq: expected masks are queued per driven chunk
// from an arithmetic patch model and compared when p_en_valid appears.
module tb_pe_enable_seq;
  localparam int NUM_PE = 8;
  localparam int SZW    = 4;
  localparam int DIMW   = 10;

  typedef struct {
    logic [NUM_PE-1:0] m;
    logic [NUM_PE-1:0] r;
    logic              re;
    logic              fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  pe_enable_seq_if #(.NUM_PE(NUM_PE), .SZW(SZW), .DIMW(DIMW)) bus ();

  pe_enable_seq #(.NUM_PE(NUM_PE), .SZW(SZW), .DIMW(DIMW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [NUM_PE-1:0] model_mask(int p, int s, int w, int r, int c);
    logic [NUM_PE-1:0] m;
    int x;
    m = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      x = c * NUM_PE + i;
      if (r >= p - 1 && ((r - (p - 1)) % s) == 0 &&
          x < w && x >= p - 1 && ((x - (p - 1)) % s) == 0)
        m[i] = 1'b1;
    end
    return m;
  endfunction

  // Scoreboard: every p_en_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.p_en_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: p_en_valid=1 with no chunk pending, p_en=%h", bus.p_en);
      end else begin
        mon_e = q.pop_front();
        checks += 4;
        if (bus.p_en !== mon_e.m) begin
          errors++; $display("FAIL p_en: got %h expected %h", bus.p_en, mon_e.m);
        end
        if (bus.p_en_rmu !== mon_e.r) begin
          errors++; $display("FAIL p_en_rmu: got %h expected %h", bus.p_en_rmu, mon_e.r);
        end
        if (bus.row_end !== mon_e.re) begin
          errors++; $display("FAIL row_end: got %b expected %b", bus.row_end, mon_e.re);
        end
        if (bus.frame_done !== mon_e.fd) begin
          errors++; $display("FAIL frame_done: got %b expected %b", bus.frame_done, mon_e.fd);
        end
      end
    end
  end

  task automatic do_cfg(input int p, input int s, input int w, input int h);
    bus.patch_size = SZW'(p);
    bus.stride     = SZW'(s);
    bus.img_w      = DIMW'(w);
    bus.img_h      = DIMW'(h);
    bus.cfg_start  = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start  = 1'b0;
  endtask

  // Streams chunks back to back; optional rmu_stop before row stop_row and
  // early exit after max_chunks (negative = whole frame).
  task automatic run_frame(input int p, input int s, input int w, input int h,
                           input int stop_row, input int max_chunks);
    int   nch;
    int   sent;
    bit   stopped;
    exp_t e;
    nch     = (w + NUM_PE - 1) / NUM_PE;
    sent    = 0;
    stopped = 1'b0;
    for (int r = 0; r < h; r++) begin
      if (r == stop_row) begin
        bus.chunk_valid = 1'b0;
        bus.rmu_stop    = 1'b1;
        @(posedge clk); #1;
        bus.rmu_stop    = 1'b0;
        stopped         = 1'b1;
        checks++;
        if (bus.p_en_rmu !== '0) begin
          errors++; $display("FAIL rmu_stop_edge: p_en_rmu got %h expected 00", bus.p_en_rmu);
        end
      end
      for (int c = 0; c < nch; c++) begin
        if (max_chunks >= 0 && sent == max_chunks) begin
          bus.chunk_valid = 1'b0;
          return;
        end
        e.m  = model_mask(p, s, w, r, c);
        e.r  = stopped ? '0 : e.m;
        e.re = (c == nch - 1);
        e.fd = (c == nch - 1) && (r == h - 1);
        q.push_back(e);
        bus.chunk_valid = 1'b1;
        @(posedge clk); #1;
        sent++;
      end
    end
    bus.chunk_valid = 1'b0;
    @(posedge clk); #1;
    checks += 2;
    if (q.size() != 0) begin
      errors++; $display("FAIL frame_outputs: %0d chunks got no p_en_valid, expected 0", q.size());
    end
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_after_frame: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.cfg_start = 1'b0; bus.chunk_valid = 1'b0; bus.rmu_stop = 1'b0;
    bus.patch_size = '0; bus.stride = '0; bus.img_w = '0; bus.img_h = '0;
    rst = 1'b0;
    #3;
    checks++;
    if ({bus.busy, bus.cfg_err, bus.p_en, bus.p_en_valid, bus.p_en_rmu, bus.row_end, bus.frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b cfg_err=%b p_en=%h valid=%b rmu=%h re=%b fd=%b expected all 0",
               bus.busy, bus.cfg_err, bus.p_en, bus.p_en_valid, bus.p_en_rmu, bus.row_end, bus.frame_done);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_cfg(3, 1, 8, 3);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy: got %b expected 1", bus.busy);
    end
    run_frame(3, 1, 8, 3, -1, -1);
  endtask

  task automatic test_stride();
    do_cfg(3, 2, 12, 5);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL stride_busy: got %b expected 1", bus.busy);
    end
    run_frame(3, 2, 12, 5, -1, -1);
  endtask

  task automatic test_large_patch();
    do_cfg(7, 7, 16, 7);
    run_frame(7, 7, 16, 7, -1, -1);
  endtask

  task automatic test_illegal();
    do_cfg(3, 0, 8, 8);
    checks += 2;
    if (bus.cfg_err !== 1'b1) begin
      errors++; $display("FAIL cfg_err_s0: got %b expected 1", bus.cfg_err);
    end
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_s0: got %b expected 0", bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      errors++; $display("FAIL cfg_err_pulse: got %b expected 0", bus.cfg_err);
    end
    do_cfg(5, 1, 4, 8);
    checks += 2;
    if (bus.cfg_err !== 1'b1) begin
      errors++; $display("FAIL cfg_err_p_gt_w: got %b expected 1", bus.cfg_err);
    end
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_p_gt_w: got %b expected 0", bus.busy);
    end
    bus.chunk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.p_en_valid !== 1'b0) begin
        errors++; $display("FAIL idle_chunk: p_en_valid got %b expected 0", bus.p_en_valid);
      end
    end
    bus.chunk_valid = 1'b0;
  endtask

  task automatic test_rmu_stop();
    do_cfg(3, 1, 8, 4);
    run_frame(3, 1, 8, 4, 3, -1);
    do_cfg(3, 1, 8, 3);
    run_frame(3, 1, 8, 3, -1, -1);
  endtask

  task automatic test_reset_mid_frame();
    do_cfg(2, 1, 16, 4);
    run_frame(2, 1, 16, 4, -1, 3);
    @(negedge clk); #1;
    checks += 2;
    if (bus.p_en !== 8'hFE) begin
      errors++; $display("FAIL mid_frame_mask: got %h expected fe", bus.p_en);
    end
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL mid_frame_busy: got %b expected 1", bus.busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.cfg_err, bus.p_en, bus.p_en_valid, bus.p_en_rmu, bus.row_end, bus.frame_done} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b p_en=%h valid=%b rmu=%h expected all 0",
               bus.busy, bus.p_en, bus.p_en_valid, bus.p_en_rmu);
    end
    @(posedge clk); #1 rst = 1'b1;
    bus.chunk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.p_en_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_chunk: valid=%b busy=%b expected 0 0", bus.p_en_valid, bus.busy);
      end
    end
    bus.chunk_valid = 1'b0;
    do_cfg(3, 1, 8, 3);
    run_frame(3, 1, 8, 3, -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_large_patch();
    test_illegal();
    test_rmu_stop();
    test_reset_mid_frame();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_enable_seq.md
Name: pe_enable_seq

Overview:
- Parametrised successor to the fixed 8-lane, 3/5/7-patch processor enable generator.
- Streams one NUM_PE-column chunk of an input frame per `chunk_valid` and emits a per-lane enable mask.
- A lane's bit is set when its column completes a valid convolution patch window.
- Enables are computed arithmetically, not from per-(patch, stride) tables, so any patch/stride/image size within limits is supported. Supports vertical stride, row/frame tracking, config checking, and a gated RMU copy of the mask.

Parameters:
- NUM_PE, 8, number of processor lanes (mask width).
- SZW, 4, bit width of patch_size and stride.
- DIMW, 10, bit width of image dimensions and row/column counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_start  in  1  latch config and begin frame (IDLE only).
- patch_size  in  SZW  patch edge P.
- stride  in  SZW  stride S (horizontal and vertical).
- img_w  in  DIMW  frame width W in columns.
- img_h  in  DIMW  frame height H in rows.
- chunk_valid  in  1  next NUM_PE-column chunk present this cycle.
- rmu_stop  in  1  sticky request to zero p_en_rmu.
- busy  out  1  high in RUN.
- cfg_err  out  1  one-cycle pulse on rejected config.
- p_en  out  NUM_PE  enable mask; bit i = lane i.
- p_en_valid  out  1  p_en updated this cycle.
- p_en_rmu  out  NUM_PE  p_en copy for RMU, or 0 once stopped.
- row_end  out  1  with p_en_valid: last chunk of a row.
- frame_done  out  1  with p_en_valid: last chunk of frame.

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0; all counters 0; stop flag 0.
- FSM IDLE -> RUN on cfg_start with a legal config. RUN -> IDLE on the cycle frame_done is driven.
- Illegal config: P==0, S==0, S>P, P>W or P>H. On cfg_start with an illegal config, pulse cfg_err and stay IDLE.
- On a legal cfg_start, latch P, S, W, H; clear col_base, row, the stop flag, and both phases.
  - Column phase starts at P-1; row phase starts at P-1.
- In IDLE, chunk_valid is ignored. In RUN, cfg_start is ignored.
- Lane i column: x = col_base + i.
- Row r enabled iff r >= P-1 and (r-(P-1)) mod S == 0.
  - Tracked by a row-phase down-counter: enabled when it is 0, reloaded to S-1.
  - No divider.
- Mask rule: bit i = row_enabled AND x < W AND x >= P-1 AND (x-(P-1)) mod S == 0.
  - Computed by walking a column-phase counter across lanes 0..NUM_PE-1 within the chunk.
  - The phase after lane NUM_PE-1 is registered for the next chunk of the same row.
- Latency: chunk_valid at edge t yields p_en, p_en_valid, row_end and frame_done at t+1.
  - p_en_valid pulses for one cycle; p_en holds its value otherwise.
- Last chunk of a row: col_base+NUM_PE >= W.
  - row_end=1; col_base <- 0; column phase <- P-1; row <- row+1; row phase advances.
  - Otherwise col_base <- col_base+NUM_PE.
- Last chunk of the frame: last chunk of row H-1.
  - row_end=1 and frame_done=1 in the same cycle; the FSM returns to IDLE.
- Arithmetic: col_base, row and phases are DIMW bits; comparisons are unsigned. Lanes beyond W are always 0.
- RMU gating: rmu_stop sets a sticky stop flag, cleared only by reset or a legal cfg_start.
  - p_en_rmu is registered from the same next-mask value as p_en, updated on chunk_valid.
  - p_en_rmu is forced to 0 while the stop flag is set, including the cycle after rmu_stop rises.
- Reset mid-frame: immediate return to IDLE with all outputs 0. A new cfg_start is needed.

Test Plan:
- NUM_PE=8, P=3, S=1, W=8, H=3; 3 chunks -> masks 0x00, 0x00, 0xFC; row_end on all three; frame_done with the third.
- P=3, S=2, W=12, H=5; 10 chunks -> only rows 2 and 4 nonzero, each 0x54 then 0x05; frame_done on the 10th p_en_valid; busy low the next cycle.
- P=7, S=7, W=16, H=7 -> row 6 gives 0x40 then 0x20; rows 0..5 give 0x00.
- cfg_start with S=0, then with P=5/W=4 -> cfg_err pulse each time; busy stays 0; subsequent chunk_valid gives no p_en_valid.
- P=3, S=1, W=8, H=4; assert rmu_stop after row 2 -> p_en continues 0xFC; p_en_rmu 0 from then on; a new legal cfg_start re-enables p_en_rmu.
- Drop rst mid-row of a running frame -> all outputs 0 asynchronously; chunk_valid ignored until a new cfg_start; the new frame starts at row 0, col 0.
